conv1x1_arbiter: RTL
====================

// Module: conv1x1_arbiter
// PURPOSE
//  Round-robin arbiter sharing one conv1x1 pixel datapath among NUM_REQ stream requesters.
//  The datapath is a fixed-latency pipeline: 16-bit Din/dataEn in, Dout/DoutEn out LAT cycles later, no backpressure.
//  Tracks the owner of every in-flight beat in a tag pipeline and routes each result back to its requester.
//  Sits between the ISP channel front-ends and the shared conv1x1 instance.
// PARAMETERS
//  NUM_REQ   4   number of requesters (2..8)
//  DW        16  pixel width; must equal the conv1x1 data width
//  LAT       3   conv1x1 latency, dataEn -> DoutEn, in cycles
//  BURST_LEN 8   beats per grant when CONV1X1_ARB_BURST_EN is defined (1..255)
// PORTS
//  clk          in   1           clock, rising edge
//  rst          in   1           synchronous, active-high reset
//  req_valid    in   NUM_REQ     per-requester beat valid
//  req_data     in   NUM_REQ*DW  per-requester pixel; requester i occupies [i*DW +: DW]
//  req_ready    out  NUM_REQ     one-hot grant; beat accepted when valid & ready
//  conv_din     out  DW          to conv1x1 Din
//  conv_en      out  1           to conv1x1 dataEn
//  conv_dout    in   DW          from conv1x1 Dout
//  conv_douten  in   1           from conv1x1 DoutEn
//  rsp_valid    out  NUM_REQ     one-hot result strobe to the owning requester
//  rsp_data     out  DW          result pixel, shared by all requesters
//  inflight     out  3           beats currently inside conv1x1 (0..LAT)
//  err_tag      out  1           sticky tag/DoutEn mismatch flag
// BEHAVIOUR
//  - Reset: req_ready=0, conv_din=0, conv_en=0, rsp_valid=0, rsp_data=0, inflight=0, err_tag=0,
//    rr_ptr=0, tag pipe cleared. Reset mid-operation drops all in-flight beats; no rsp is issued for them.
//  - Arbitration, combinational: grant the first i with req_valid[i], searching from rr_ptr upward
//    with wrap-around. req_ready = one-hot(grant), or 0 if no req_valid is set.
//  - Accept at cycle T: conv_din<=req_data[grant], conv_en<=1, registered at T+1. With no accept, conv_en<=0 and conv_din holds.
//  - rr_ptr <= grant+1 mod NUM_REQ on every accept. It is unchanged when idle.
//  - Tag pipe: LAT stages of {vld,id[2:0]}. Stage0 loads {conv_en, id of the beat on conv_din}. Shifts every cycle.
//  - On conv_douten: rsp_data<=conv_dout, rsp_valid<=onehot(tail.id) at the next edge. Otherwise rsp_valid<=0 and rsp_data holds.
//  - Total latency: accept at T -> rsp_valid at T+LAT+2 (T+5 at default).
//  - Mismatch: conv_douten != tail.vld sets err_tag=1. It stays 1 until rst. A mismatch with douten=1 and vld=0 produces no rsp_valid.
//  - inflight: +1 on conv_en, -1 on tail.vld, both in the same cycle -> unchanged. Never exceeds LAT.
//  - Full throughput: one beat per cycle. A single requester with continuous valid is granted every cycle.
//  - req_data must be stable while req_valid=1 and ready=0. A requester may drop valid without an accept.
// CONFIGURATION
//  CONV1X1_ARB_BURST_EN defined:
//    - The grant locks on the current owner for BURST_LEN accepted beats.
//    - The lock releases early when the owner drops req_valid. A release on early drop counts as a burst end.
//    - rr_ptr advances only at burst end. An 8-bit beat counter resets to 0 at burst end and on rst.
//  Undefined: arbitration re-runs every beat (per-beat round robin); no counter is synthesised.
// TESTING
//  1 Reset: assert rst 2 cycles with all valid=1 -> all outputs 0, no conv_en, err_tag=0.
//  2 Single requester: req1 sends 0x0010..0x0019 continuously; conv1x1 model is identity, LAT=3.
//    -> 10 beats in 10 cycles; rsp_valid=4'b0010 starting T+5 with data 0x0010..0x0019 in order.
//  3 All four valid continuously (burst off) -> grants 0,1,2,3,0...; rsp_valid cycles 0001,0010,0100,1000; inflight==3 in steady state.
//  4 Burst on, BURST_LEN=4, req0 and req2 valid -> 4 beats to 0, then 4 to 2. With req0 dropping valid after 2 beats -> switch to 2 immediately.
//  5 Inject spurious conv_douten=1 with empty pipe -> err_tag=1 next cycle and stays 1; no rsp_valid.
//  6 Assert rst with 3 beats in flight -> no rsp_valid after reset; inflight=0; the next accept restarts at rr_ptr=0.

Source files
------------

// File: rtl/conv1x1_arbiter.sv
// Round-robin arbiter sharing one fixed-latency conv1x1 datapath.
// Define CONV1X1_ARB_BURST_EN to lock grants for BURST_LEN beats.
module conv1x1_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DW        = 16,
  parameter int LAT       = 3,
  parameter int BURST_LEN = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*DW-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [DW-1:0]         conv_din,
  output logic                  conv_en,
  input  logic [DW-1:0]         conv_dout,
  input  logic                  conv_douten,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [DW-1:0]         rsp_data,
  output logic [2:0]            inflight,
  output logic                  err_tag
);

  localparam int IW = 3;
  localparam logic [NUM_REQ-1:0] ONE =
    {{(NUM_REQ-1){1'b0}}, 1'b1};

  function automatic logic [IW-1:0] wrap_inc(
    input logic [IW-1:0] v
  );
    if (int'(v) >= NUM_REQ - 1) return '0;
    return v + 3'd1;
  endfunction

  logic [7:0]    valid_ext;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] search_base;
  logic [IW-1:0] cand;
  logic [IW-1:0] grant_id;
  logic          grant_any;
  logic          accept;
  logic [DW-1:0] sel_data;
  logic [IW-1:0] conv_id;

  logic [LAT-1:0] tag_vld;
  logic [IW-1:0]  tag_id [LAT];
  logic           tail_vld;
  logic [IW-1:0]  tail_id;

  assign valid_ext = 8'(req_valid);

`ifdef CONV1X1_ARB_BURST_EN
  logic [7:0]    beat_cnt;
  logic [IW-1:0] lock_id;
  logic          locked;
  logic          owner_on;
  localparam logic [7:0] BL8 = 8'(BURST_LEN);

  assign locked   = beat_cnt != 8'd0;
  assign owner_on = valid_ext[lock_id];
  // an owner that drops valid ends its burst this cycle
  assign search_base = (locked && !owner_on) ?
                       wrap_inc(lock_id) : rr_ptr;
`else
  assign search_base = rr_ptr;
`endif

  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    cand      = search_base;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_any && valid_ext[cand]) begin
        grant_any = 1'b1;
        grant_id  = cand;
      end
      cand = wrap_inc(cand);
    end
`ifdef CONV1X1_ARB_BURST_EN
    if (locked && owner_on) begin
      grant_any = 1'b1;
      grant_id  = lock_id;
    end
`endif
  end

  assign accept    = grant_any && !rst;
  assign req_ready = accept ? (ONE << grant_id) : '0;
  assign sel_data  = req_data[int'(grant_id)*DW +: DW];

`ifdef CONV1X1_ARB_BURST_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= '0;
      beat_cnt <= 8'd0;
      lock_id  <= '0;
    end else if (accept && locked && owner_on) begin
      if (beat_cnt + 8'd1 == BL8) begin
        beat_cnt <= 8'd0;
        rr_ptr   <= wrap_inc(grant_id);
      end else begin
        beat_cnt <= beat_cnt + 8'd1;
      end
    end else if (accept) begin
      if (locked) rr_ptr <= wrap_inc(lock_id);
      if (BL8 == 8'd1) begin
        beat_cnt <= 8'd0;
        rr_ptr   <= wrap_inc(grant_id);
      end else begin
        beat_cnt <= 8'd1;
        lock_id  <= grant_id;
      end
    end else if (locked && !owner_on) begin
      beat_cnt <= 8'd0;
      rr_ptr   <= wrap_inc(lock_id);
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= wrap_inc(grant_id);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      conv_en  <= 1'b0;
      conv_din <= '0;
      conv_id  <= '0;
    end else begin
      conv_en <= accept;
      if (accept) begin
        conv_din <= sel_data;
        conv_id  <= grant_id;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld <= '0;
      for (int k = 0; k < LAT; k++) tag_id[k] <= '0;
    end else begin
      tag_vld[0] <= conv_en;
      tag_id[0]  <= conv_id;
      for (int k = 1; k < LAT; k++) begin
        tag_vld[k] <= tag_vld[k-1];
        tag_id[k]  <= tag_id[k-1];
      end
    end
  end

  assign tail_vld = tag_vld[LAT-1];
  assign tail_id  = tag_id[LAT-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
      err_tag   <= 1'b0;
      inflight  <= 3'd0;
    end else begin
      rsp_valid <= '0;
      if (conv_douten) begin
        rsp_data <= conv_dout;
        if (tail_vld) rsp_valid <= ONE << tail_id;
      end
      if (conv_douten != tail_vld) err_tag <= 1'b1;
      unique case ({conv_en, tail_vld})
        2'b10:   inflight <= inflight + 3'd1;
        2'b01:   inflight <= inflight - 3'd1;
        default: inflight <= inflight;
      endcase
    end
  end

endmodule
